// File: rtl/arb8_mux_ctrl.sv
// Round-robin arbiter for eight requesters sharing one 8:1 data mux.
// Each grant carries at most MAX_BURST accepted beats, then the pointer rotates past the winner.
module arb8_mux_ctrl #(
   parameter int WIDTH     = 64,
   parameter int MAX_BURST = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            req,
   input  logic [7:0][WIDTH-1:0] data_in,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [WIDTH-1:0]      out_data,
   output logic [2:0]            sel,
   output logic [7:0]            ack,
   output logic                  busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

   state_t     state_q, state_d;
   logic [2:0] sel_q, sel_d;
   logic [2:0] ptr_q, ptr_d;
   logic [3:0] cnt_q, cnt_d;
   logic       beat_acc;

   // First set request at or after p, wrapping mod 8; later offsets are overwritten by nearer ones.
   function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
      logic [2:0] win;
      logic [2:0] idx;
      win = p;
      for (int i = 7; i >= 0; i--) begin
         idx = p + 3'(i);
         if (r[idx]) begin
            win = idx;
         end
      end
      return win;
   endfunction

   // State register; reset also drops any beat in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         sel_q   <= 3'd0;
         ptr_q   <= 3'd0;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state: arbitrate in IDLE, count beats and decide release in GRANT.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (req != 8'h00) begin
               sel_d   = rr_pick(req, ptr_q);
               cnt_d   = 4'd0;
               state_d = GRANT;
            end else begin
               state_d = IDLE;
            end
         end
         GRANT: begin
            if (!req[sel_q]) begin
               state_d = IDLE;
               ptr_d   = sel_q + 3'd1;
               cnt_d   = 4'd0;
            end else if (beat_acc) begin
               if ((cnt_q + 4'd1) == BURST_LIM) begin
                  state_d = IDLE;
                  ptr_d   = sel_q + 3'd1;
                  cnt_d   = 4'd0;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs: valid and ack follow the granted lane's request within the cycle.
   always_comb begin
      busy      = (state_q == GRANT);
      out_valid = busy && req[sel_q];
      beat_acc  = out_valid && out_ready;
      if (beat_acc) begin
         ack = 8'h01 << sel_q;
      end else begin
         ack = 8'h00;
      end
      out_data = data_in[sel_q];
      sel      = sel_q;
   end

endmodule

// File: tb/tb_arb8_mux_ctrl.sv
// Directed bench for arb8_mux_ctrl: one instance with burst 4, one with burst 1 for rotation order.
module tb_arb8_mux_ctrl;

   localparam logic [63:0] LANE_BASE = 64'hA5A5_0000_0000_0000;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [7:0]           req;
   logic [7:0][63:0]     data_in;
   logic                 out_ready;

   logic                 out_valid, busy;
   logic [63:0]          out_data;
   logic [2:0]           sel;
   logic [7:0]           ack;

   logic                 b_valid, b_busy;
   logic [63:0]          b_data;
   logic [2:0]           b_sel;
   logic [7:0]           b_ack;

   int errors = 0;
   int checks = 0;

   arb8_mux_ctrl #(.WIDTH(64), .MAX_BURST(4)) dut (
      .clk(clk), .reset(reset), .req(req), .data_in(data_in), .out_ready(out_ready),
      .out_valid(out_valid), .out_data(out_data), .sel(sel), .ack(ack), .busy(busy)
   );

   arb8_mux_ctrl #(.WIDTH(64), .MAX_BURST(1)) dut_b1 (
      .clk(clk), .reset(reset), .req(req), .data_in(data_in), .out_ready(out_ready),
      .out_valid(b_valid), .out_data(b_data), .sel(b_sel), .ack(b_ack), .busy(b_busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      req = 8'h00;
      out_ready = 1'b0;
      step();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req = 8'h00;
      out_ready = 1'b0;
      #1;
      checks++;
      if ({out_valid, busy, sel, ack} !== {1'b0, 1'b0, 3'd0, 8'h00}) begin
         errors++; $display("FAIL reset_init: got %h expected %h", {out_valid, busy, sel, ack}, {1'b0, 1'b0, 3'd0, 8'h00});
      end
      checks++;
      if (out_data !== LANE_BASE) begin
         errors++; $display("FAIL reset_data: got %h expected %h", out_data, LANE_BASE);
      end
      step();
      reset = 1'b0;
      req = 8'h01;
      step();
      checks++;
      if ({out_valid, busy, sel, ack} !== {1'b1, 1'b1, 3'd0, 8'h00}) begin
         errors++; $display("FAIL reset_pre_grant0: got %h expected %h", {out_valid, busy, sel, ack}, {1'b1, 1'b1, 3'd0, 8'h00});
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({out_valid, busy, sel, ack} !== {1'b0, 1'b0, 3'd0, 8'h00}) begin
         errors++; $display("FAIL reset_mid_grant0: got %h expected %h", {out_valid, busy, sel, ack}, {1'b0, 1'b0, 3'd0, 8'h00});
      end
      step();
      reset = 1'b0;
      req = 8'h10;
      step();
      checks++;
      if ({out_valid, busy, sel, ack} !== {1'b1, 1'b1, 3'd4, 8'h00}) begin
         errors++; $display("FAIL reset_pre_grant4: got %h expected %h", {out_valid, busy, sel, ack}, {1'b1, 1'b1, 3'd4, 8'h00});
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({out_valid, busy, sel, ack} !== {1'b0, 1'b0, 3'd0, 8'h00}) begin
         errors++; $display("FAIL reset_mid_grant4: got %h expected %h", {out_valid, busy, sel, ack}, {1'b0, 1'b0, 3'd0, 8'h00});
      end
      checks++;
      if (out_data !== LANE_BASE) begin
         errors++; $display("FAIL reset_mid_data: got %h expected %h", out_data, LANE_BASE);
      end
      step();
      reset = 1'b0;
      req = 8'h00;
      #1;
   endtask

   task automatic test_round_robin();
      pulse_reset();
      req = 8'hFF;
      out_ready = 1'b1;
      #1;
      checks++;
      if ({b_valid, b_busy, b_ack} !== {1'b0, 1'b0, 8'h00}) begin
         errors++; $display("FAIL rr_idle_start: got %h expected %h", {b_valid, b_busy, b_ack}, {1'b0, 1'b0, 8'h00});
      end
      for (int g = 0; g < 9; g++) begin
         int lane;
         logic [7:0] exp_ack;
         lane = g % 8;
         exp_ack = 8'h01 << lane;
         step();
         checks++;
         if ({b_valid, b_busy, b_sel, b_ack} !== {1'b1, 1'b1, 3'(lane), exp_ack}) begin
            errors++; $display("FAIL rr_grant%0d: got %h expected %h", g, {b_valid, b_busy, b_sel, b_ack}, {1'b1, 1'b1, 3'(lane), exp_ack});
         end
         checks++;
         if (b_data !== LANE_BASE + 64'(lane)) begin
            errors++; $display("FAIL rr_data%0d: got %h expected %h", g, b_data, LANE_BASE + 64'(lane));
         end
         step();
         checks++;
         if ({b_valid, b_busy, b_ack} !== {1'b0, 1'b0, 8'h00}) begin
            errors++; $display("FAIL rr_idle%0d: got %h expected %h", g, {b_valid, b_busy, b_ack}, {1'b0, 1'b0, 8'h00});
         end
      end
      req = 8'h00;
      step();
   endtask

   task automatic test_single();
      pulse_reset();
      data_in[2] = 64'd24556;
      req = 8'h04;
      out_ready = 1'b1;
      #1;
      checks++;
      if ({out_valid, busy, sel, ack} !== {1'b0, 1'b0, 3'd0, 8'h00}) begin
         errors++; $display("FAIL single_arb_cycle: got %h expected %h", {out_valid, busy, sel, ack}, {1'b0, 1'b0, 3'd0, 8'h00});
      end
      for (int b = 0; b < 4; b++) begin
         step();
         checks++;
         if ({out_valid, busy, sel, ack} !== {1'b1, 1'b1, 3'd2, 8'h04}) begin
            errors++; $display("FAIL single_beat%0d: got %h expected %h", b, {out_valid, busy, sel, ack}, {1'b1, 1'b1, 3'd2, 8'h04});
         end
         checks++;
         if (out_data !== 64'd24556) begin
            errors++; $display("FAIL single_data%0d: got %0d expected %0d", b, out_data, 64'd24556);
         end
      end
      step();
      checks++;
      if ({out_valid, busy, sel, ack} !== {1'b0, 1'b0, 3'd2, 8'h00}) begin
         errors++; $display("FAIL single_release: got %h expected %h", {out_valid, busy, sel, ack}, {1'b0, 1'b0, 3'd2, 8'h00});
      end
      step();
      checks++;
      if ({out_valid, busy, sel, ack} !== {1'b1, 1'b1, 3'd2, 8'h04}) begin
         errors++; $display("FAIL single_regrant: got %h expected %h", {out_valid, busy, sel, ack}, {1'b1, 1'b1, 3'd2, 8'h04});
      end
      step();
      req = 8'h00;
      #1;
      checks++;
      if ({out_valid, busy, sel, ack} !== {1'b0, 1'b1, 3'd2, 8'h00}) begin
         errors++; $display("FAIL single_withdraw: got %h expected %h", {out_valid, busy, sel, ack}, {1'b0, 1'b1, 3'd2, 8'h00});
      end
      step();
      checks++;
      if ({out_valid, busy, sel, ack} !== {1'b0, 1'b0, 3'd2, 8'h00}) begin
         errors++; $display("FAIL single_idle_end: got %h expected %h", {out_valid, busy, sel, ack}, {1'b0, 1'b0, 3'd2, 8'h00});
      end
   endtask

   task automatic test_backpressure();
      pulse_reset();
      data_in[6] = 64'd132346;
      req = 8'h40;
      out_ready = 1'b0;
      step();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({out_valid, busy, sel, ack} !== {1'b1, 1'b1, 3'd6, 8'h00}) begin
            errors++; $display("FAIL bp_stall%0d: got %h expected %h", i, {out_valid, busy, sel, ack}, {1'b1, 1'b1, 3'd6, 8'h00});
         end
         checks++;
         if (out_data !== 64'd132346) begin
            errors++; $display("FAIL bp_data%0d: got %0d expected %0d", i, out_data, 64'd132346);
         end
         step();
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if ({out_valid, busy, sel, ack} !== {1'b1, 1'b1, 3'd6, 8'h40}) begin
         errors++; $display("FAIL bp_accept: got %h expected %h", {out_valid, busy, sel, ack}, {1'b1, 1'b1, 3'd6, 8'h40});
      end
      step();
      out_ready = 1'b0;
      #1;
      checks++;
      if ({out_valid, busy, sel, ack} !== {1'b1, 1'b1, 3'd6, 8'h00}) begin
         errors++; $display("FAIL bp_single_ack: got %h expected %h", {out_valid, busy, sel, ack}, {1'b1, 1'b1, 3'd6, 8'h00});
      end
      req = 8'h00;
      step();
   endtask

   task automatic test_withdrawal();
      pulse_reset();
      req = 8'h28;
      out_ready = 1'b1;
      step();
      checks++;
      if ({out_valid, busy, sel, ack} !== {1'b1, 1'b1, 3'd3, 8'h08}) begin
         errors++; $display("FAIL wd_grant3: got %h expected %h", {out_valid, busy, sel, ack}, {1'b1, 1'b1, 3'd3, 8'h08});
      end
      step();
      req = 8'h20;
      #1;
      checks++;
      if ({out_valid, busy, sel, ack} !== {1'b0, 1'b1, 3'd3, 8'h00}) begin
         errors++; $display("FAIL wd_no_ack: got %h expected %h", {out_valid, busy, sel, ack}, {1'b0, 1'b1, 3'd3, 8'h00});
      end
      step();
      checks++;
      if ({out_valid, busy, sel, ack} !== {1'b0, 1'b0, 3'd3, 8'h00}) begin
         errors++; $display("FAIL wd_idle: got %h expected %h", {out_valid, busy, sel, ack}, {1'b0, 1'b0, 3'd3, 8'h00});
      end
      checks++;
      if (dut.ptr_q !== 3'd4) begin
         errors++; $display("FAIL wd_ptr: got %0d expected %0d", dut.ptr_q, 3'd4);
      end
      step();
      checks++;
      if ({out_valid, busy, sel, ack} !== {1'b1, 1'b1, 3'd5, 8'h20}) begin
         errors++; $display("FAIL wd_grant5: got %h expected %h", {out_valid, busy, sel, ack}, {1'b1, 1'b1, 3'd5, 8'h20});
      end
      req = 8'h00;
      step();
   endtask

   task automatic test_wrap();
      pulse_reset();
      req = 8'h40;
      out_ready = 1'b1;
      step();
      checks++;
      if ({out_valid, busy, sel, ack} !== {1'b1, 1'b1, 3'd6, 8'h40}) begin
         errors++; $display("FAIL wrap_grant6: got %h expected %h", {out_valid, busy, sel, ack}, {1'b1, 1'b1, 3'd6, 8'h40});
      end
      step();
      req = 8'h81;
      #1;
      step();
      checks++;
      if (dut.ptr_q !== 3'd7) begin
         errors++; $display("FAIL wrap_ptr7: got %0d expected %0d", dut.ptr_q, 3'd7);
      end
      step();
      checks++;
      if ({out_valid, busy, sel, ack} !== {1'b1, 1'b1, 3'd7, 8'h80}) begin
         errors++; $display("FAIL wrap_grant7: got %h expected %h", {out_valid, busy, sel, ack}, {1'b1, 1'b1, 3'd7, 8'h80});
      end
      checks++;
      if (out_data !== LANE_BASE + 64'd7) begin
         errors++; $display("FAIL wrap_data7: got %h expected %h", out_data, LANE_BASE + 64'd7);
      end
      step();
      req = 8'h01;
      #1;
      step();
      checks++;
      if ({out_valid, busy, sel, ack} !== {1'b0, 1'b0, 3'd7, 8'h00}) begin
         errors++; $display("FAIL wrap_idle: got %h expected %h", {out_valid, busy, sel, ack}, {1'b0, 1'b0, 3'd7, 8'h00});
      end
      checks++;
      if (dut.ptr_q !== 3'd0) begin
         errors++; $display("FAIL wrap_ptr0: got %0d expected %0d", dut.ptr_q, 3'd0);
      end
      step();
      checks++;
      if ({out_valid, busy, sel, ack} !== {1'b1, 1'b1, 3'd0, 8'h01}) begin
         errors++; $display("FAIL wrap_grant0: got %h expected %h", {out_valid, busy, sel, ack}, {1'b1, 1'b1, 3'd0, 8'h01});
      end
      req = 8'h00;
      step();
   endtask

   initial begin
      for (int k = 0; k < 8; k++) begin
         data_in[k] = LANE_BASE + 64'(k);
      end
      test_reset();
      test_round_robin();
      test_single();
      test_backpressure();
      test_withdrawal();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/arb8_mux_ctrl.md
Name: arb8_mux_ctrl

Overview:
Round-robin arbiter and sequencer that shares one 64-bit 8:1 mux datapath among eight requesters.
- Picks one requester and drives the 3-bit mux select.
- Presents the selected requester's data downstream with a valid/ready handshake.
- Returns a per-requester ack for every accepted beat.
- Limits each grant to a bounded burst so that all requesters make progress.
- Sits between the eight producers and a single shared consumer, such as a register-file write port or a memory/bus port.

Parameters:
WIDTH, 64, data width of each requester lane and of the output.
MAX_BURST, 4, maximum accepted beats per grant before forced rotation (range 1..15).

Ports:
clk  input  1  system clock, all state updates on its rising edge
reset  input  1  asynchronous, active-high reset
req  input  8  per-requester request; held high while the requester has data
data_in  input  8xWIDTH  packed per-requester data, lane k = data_in[k]
out_ready  input  1  downstream can accept a beat this cycle
out_valid  output  1  out_data holds a valid beat
out_data  output  WIDTH  data of the granted lane, data_in[sel], through the internal 8:1 mux
sel  output  3  registered index of the current or last granted requester
ack  output  8  one-hot; ack[sel]=1 in a cycle where a beat is accepted
busy  output  1  1 while in GRANT state

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-transfer):
  - state=IDLE, sel=0, ptr=0, beat count=0.
  - out_valid=0, ack=0, busy=0.
  - out_data = data_in[0], because the mux is driven by sel=0.
  - A beat in flight is dropped with no ack.
- States:
  - IDLE: out_valid=0, ack=0.
  - GRANT: busy=1.
- Arbitration (IDLE only):
  - If req != 0 at a rising edge, the winner is the first set bit scanning ptr, ptr+1, ... wrapping mod 8.
  - sel <= winner, count <= 0, state <= GRANT.
  - If req == 0, stay in IDLE and hold sel.
- Latency: req rising before edge N gives out_valid=1 in the cycle after edge N. There is one arbitration cycle in IDLE.
- In GRANT:
  - out_valid = req[sel] (combinational).
  - out_data = data_in[sel].
  - Beat accepted iff out_valid && out_ready. On acceptance, ack[sel]=1 combinationally in that cycle and count increments at the edge.
- Release from GRANT to IDLE happens at the edge when either:
  - req[sel]==0, where the requester withdrew; this is legal even with out_ready=1 and produces no ack; or
  - an accepted beat makes count reach MAX_BURST.
- On release:
  - ptr <= sel+1 (mod 8; 7 wraps to 0).
  - sel holds its value in IDLE until the next grant.
- Simultaneous events:
  - An accept and the MAX_BURST limit on the same beat: the beat is acked, then release.
  - A new request from another lane during GRANT is not considered until IDLE.
  - The granted requester re-requesting right after release competes from ptr, so it loses to any other pending requester.
- out_ready may toggle freely. While out_valid && !out_ready, sel and out_data remain stable (no arbitration change).
- Count width is 4 bits. Count never exceeds MAX_BURST.
- Only one ack bit is set in any cycle. ack=0 whenever out_valid=0 or out_ready=0.

Test Plan:
1. Reset check: assert reset mid-GRANT with req=8'h01, out_ready=0. Required: out_valid=0, busy=0, sel=0, ack=0 immediately, before the next clock edge.
2. Single requester: req=8'h04, data_in[2]=64'd24556, out_ready=1, MAX_BURST=4. Required:
   - one IDLE cycle, then 4 beats with sel=2, out_data=24556, ack=8'h04 on each beat;
   - release, then re-grant to lane 2 after one IDLE cycle.
3. Round-robin fairness: req=8'hFF held, out_ready=1, MAX_BURST=1. Required: grant order 0,1,2,3,4,5,6,7,0. Each grant gives one beat followed by one IDLE cycle.
4. Backpressure: lane 6 granted with data_in[6]=64'd132346 and out_ready=0 for 5 cycles. Required: out_valid=1, sel=6, out_data=132346 stable, ack=0. When out_ready=1, ack=8'h40 on that beat only.
5. Withdrawal: lane 3 granted, req[3] dropped after 1 accepted beat, req[5] pending. Required:
   - release with no further ack for lane 3;
   - ptr=4;
   - the next grant goes to lane 5, with sel=5 one cycle after IDLE.
6. Wrap-around: ptr=7 (after a lane 6 release) with req=8'h81. Required: lane 7 is granted first. After its release, lane 0 is granted (ptr wraps 7 to 0).
